regfile_scoreboard: RTL and testbench

- Integer register file and hazard scoreboard for the Hunter_RV32 core.
- Write-back writes into the register file. The decode/issue side reads from it.
- Reads go through a valid/ready issue handshake.
- Accepted reads return both source operands registered, one cycle later.
- Issue is held off while a source or destination register still has a write pending.

---
 rtl/regfile_scoreboard.sv | 132 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with a busy-bit scoreboard and a registered operand output stage.
// Optional macro RF_BYPASS_EN forwards same-cycle write-back to the issuing operands.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_rd_en,
    output logic            out_valid,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    input  logic            out_ready
);

    localparam int NADDR = 1 << AW;

    logic [XLEN-1:0] regs_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] wr_sel;
    logic            out_valid_reg;
    logic [XLEN-1:0] rs1_data_reg;
    logic [XLEN-1:0] rs2_data_reg;

    // Address-space views padded to 2^AW entries; x0 and unimplemented addresses read as zero / never busy.
    logic [NADDR-1:0] busy_pad;
    logic [XLEN-1:0]  rd_pad [NADDR];

    logic            wb_hit;
    logic            byp1;
    logic            byp2;
    logic            hz1;
    logic            hz2;
    logic            hzd;
    logic            out_free;
    logic            fire;
    logic            set_en;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    genvar gi;
    generate
        for (gi = 0; gi < NADDR; gi++) begin : g_pad
            if (gi > 0 && gi < NREG) begin : g_real
                assign busy_pad[gi] = busy_reg[gi];
                assign rd_pad[gi]   = regs_reg[gi];
            end else begin : g_zero
                assign busy_pad[gi] = 1'b0;
                assign rd_pad[gi]   = '0;
            end
        end
    endgenerate

    assign wb_hit = wr_en && (wr_addr != '0);
    assign byp1   = wb_hit && (wr_addr == iss_rs1);
    assign byp2   = wb_hit && (wr_addr == iss_rs2);

`ifdef RF_BYPASS_EN
    assign hz1 = busy_pad[iss_rs1] && !byp1;
    assign hz2 = busy_pad[iss_rs2] && !byp2;
    assign op1 = byp1 ? wr_data : rd_pad[iss_rs1];
    assign op2 = byp2 ? wr_data : rd_pad[iss_rs2];
`else
    // Without forwarding, a source being written this cycle is only readable from the next cycle on.
    assign hz1 = busy_pad[iss_rs1] || byp1;
    assign hz2 = busy_pad[iss_rs2] || byp2;
    assign op1 = rd_pad[iss_rs1];
    assign op2 = rd_pad[iss_rs2];
`endif

    assign hzd       = iss_rd_en && busy_pad[iss_rd];
    assign out_free  = !out_valid_reg || out_ready;
    assign iss_ready = !hz1 && !hz2 && !hzd && out_free;
    assign fire      = iss_valid && iss_ready;
    assign set_en    = fire && iss_rd_en;

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign wr_sel[gi]    = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign wr_sel[gi] = wb_hit && (wr_addr == AW'(gi));
                // A new issue marking this register busy overrides a same-cycle write-back clear.
                assign busy_next[gi] = (set_en && (iss_rd == AW'(gi))) ? 1'b1 :
                                       wr_sel[gi]                      ? 1'b0 :
                                                                         busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg      <= '0;
            out_valid_reg <= 1'b0;
            rs1_data_reg  <= '0;
            rs2_data_reg  <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= wr_data;
                end
            end
            busy_reg <= busy_next;
            if (fire) begin
                out_valid_reg <= 1'b1;
                rs1_data_reg  <= op1;
                rs2_data_reg  <= op2;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_rs1_data = rs1_data_reg;
    assign out_rs2_data = rs2_data_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, x0, forwarding/stall, WAW, backpressure, mid-run reset.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_rd_en;
    logic        out_valid;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_en(iss_rd_en),
        .out_valid(out_valid), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rd_en = 0;
        out_ready = 1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic rd_en);
        iss_valid = 1; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rd; iss_rd_en = rd_en;
    endtask

    initial begin
        rst = 1;
        idle();
        tick(); tick();
        rst = 0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_rs1", out_rs1_data, 0);
        chk("reset_rs2", out_rs2_data, 0);
        chk("reset_ready", 32'(iss_ready), 1);

        // x0/x0 read
        issue(0, 0, 0, 0); #1;
        chk("x0_ready", 32'(iss_ready), 1);
        tick(); idle(); #1;
        chk("x0_out_valid", 32'(out_valid), 1);
        chk("x0_rs1", out_rs1_data, 0);
        chk("x0_rs2", out_rs2_data, 0);
        iss_rs1 = 5; iss_rs2 = 7; #1;
        chk("no_busy_ready", 32'(iss_ready), 1);
        idle();

        // write/read x5, write x0 dropped
        write(5, 32'hDEADBEEF); tick(); idle();
        issue(5, 0, 0, 0); tick(); idle(); #1;
        chk("x5_rs1", out_rs1_data, 32'hDEADBEEF);
        chk("x5_rs2", out_rs2_data, 0);
        write(0, 32'h1234); tick(); idle();
        issue(0, 5, 0, 0); tick(); idle(); #1;
        chk("x0w_rs1", out_rs1_data, 0);
        chk("x0w_rs2", out_rs2_data, 32'hDEADBEEF);

        // RAW on x7
        issue(0, 0, 7, 1); tick(); idle();
        issue(7, 0, 0, 0); #1;
        chk("raw_stall", 32'(iss_ready), 0);
        tick(); #1;
        chk("raw_out_drained", 32'(out_valid), 0);
        write(7, 32'h55); #1;
`ifdef RF_BYPASS_EN
        chk("raw_byp_ready", 32'(iss_ready), 1);
        tick(); idle(); #1;
`else
        chk("raw_nobyp_ready", 32'(iss_ready), 0);
        tick(); wr_en = 0; #1;
        chk("raw_late_ready", 32'(iss_ready), 1);
        tick(); idle(); #1;
`endif
        chk("raw_out_valid", 32'(out_valid), 1);
        chk("raw_rs1", out_rs1_data, 32'h55);

        // WAW on x3, then set-wins on same-cycle clear
        issue(0, 0, 3, 1); tick(); idle();
        issue(0, 0, 3, 1); #1;
        chk("waw_stall", 32'(iss_ready), 0);
        tick();
        write(3, 32'h33); #1;
        chk("waw_stall_wb_cycle", 32'(iss_ready), 0);
        tick();
        write(3, 32'h44); #1;
        chk("waw_ready", 32'(iss_ready), 1);
        tick(); idle();
        iss_rd = 3; iss_rd_en = 1; #1;
        chk("set_wins_busy3", 32'(iss_ready), 0);
        idle();
        write(3, 32'h66); tick(); idle(); tick();

        // backpressure
        out_ready = 0;
        issue(5, 3, 0, 0); #1;
        chk("bp_first_ready", 32'(iss_ready), 1);
        tick();
        issue(0, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_rs1", out_rs1_data, 32'hDEADBEEF);
            chk("bp_hold_rs2", out_rs2_data, 32'h66);
            chk("bp_hold_ready", 32'(iss_ready), 0);
            tick();
        end
        out_ready = 1; #1;
        chk("bp_release_ready", 32'(iss_ready), 1);
        tick();
        issue(3, 0, 0, 0); #1;
        chk("b2b_valid1", 32'(out_valid), 1);
        chk("b2b_rs2_1", out_rs2_data, 32'hDEADBEEF);
        chk("b2b_ready", 32'(iss_ready), 1);
        tick(); idle(); #1;
        chk("b2b_valid2", 32'(out_valid), 1);
        chk("b2b_rs1_2", out_rs1_data, 32'h66);
        tick(); #1;
        chk("b2b_drained", 32'(out_valid), 0);

        // reset mid-operation
        write(9, 32'h99); tick(); idle();
        out_ready = 0;
        issue(0, 0, 9, 1); tick(); idle(); out_ready = 0; #1;
        chk("prerst_valid", 32'(out_valid), 1);
        rst = 1;
        write(5, 32'h77);
        tick();
        rst = 0; idle(); #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rs1", out_rs1_data, 0);
        iss_rd = 9; iss_rd_en = 1; #1;
        chk("rst_busy9_clear", 32'(iss_ready), 1);
        idle();
        issue(9, 5, 0, 0); tick(); idle(); #1;
        chk("rst_x9", out_rs1_data, 0);
        chk("rst_x5_wb_ignored", out_rs2_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
